laser_host: RTL and testbench
=============================

LASER_HOST -- requirements
Module: laser_host

Interface
REQ-001 Parameter NPTS, default 40: points per image, sent to and scored from the LASER engine.
REQ-002 Parameter RSQ, default 16: squared coverage radius.
REQ-003 Parameter TIMEOUT, default 200000: maximum wait cycles for DONE.
REQ-004 Port CLK, input, 1: clock, all flops rising-edge.
REQ-005 Port RST, input, 1: reset, asynchronous, active-high.
REQ-006 Port LD_VALID, input, 1: load strobe for one point.
REQ-007 Port LD_X, input, 4: x coordinate of the point being loaded.
REQ-008 Port LD_Y, input, 4: y coordinate of the point being loaded.
REQ-009 Port LD_READY, output, 1: high only in S_LOAD.
REQ-010 Port LRST, output, 1: registered reset driven to the LASER engine.
REQ-011 Port LX, output, 4: registered point x driven to the engine.
REQ-012 Port LY, output, 4: registered point y driven to the engine.
REQ-013 Ports C1X, C1Y, C2X, C2Y, input, 4 each: centers returned by the engine.
REQ-014 Port DONE, input, 1: engine completion pulse.
REQ-015 Ports R_C1X, R_C1Y, R_C2X, R_C2Y, output, 4 each: captured centers.
REQ-016 Port R_COV, output, 6: covered-point count.
REQ-017 Port R_ERR, output, 1: timeout flag.
REQ-018 Port R_VALID, output, 1: one-cycle result strobe.
REQ-019 Port BUSY, output, 1: high in every state except S_LOAD.

Function
REQ-020 States SHALL be S_LOAD, S_SEND, S_WAIT, S_SCORE and S_REPORT, with no other states.
REQ-021 S_LOAD: each edge with LD_VALID=1 SHALL write {LD_X,LD_Y} to buf[ldcnt] and increment ldcnt; LRST SHALL stay 1.
REQ-022 LD_VALID outside S_LOAD SHALL be ignored, with no buffer write and no counter change.
REQ-023 The edge that accepts point NPTS-1 SHALL move to S_SEND; at that same edge LRST<=0, LX/LY<=buf[0], idx<=1.
REQ-024 S_SEND: each following edge SHALL drive LX/LY<=buf[idx] and increment idx, presenting points 0..NPTS-1 on NPTS consecutive cycles.
REQ-025 The engine samples point k on edge k+1 after LRST falls; the host SHALL insert no gaps and no bubbles.
REQ-026 After buf[NPTS-1] has been held one cycle, LX/LY<=0, the wait counter SHALL clear and the state SHALL become S_WAIT.
REQ-027 S_WAIT: on the edge sampling DONE=1, the host SHALL capture C1X/C1Y/C2X/C2Y into R_C*, set LRST<=1, R_ERR<=0 and enter S_SCORE.
REQ-028 The engine outputs are valid only while DONE=1, so capture SHALL occur on that same edge.
REQ-029 S_WAIT without DONE: the wait counter SHALL increment; when it reaches TIMEOUT the host SHALL set R_ERR<=1, R_C*<=0, R_COV<=0, LRST<=1 and enter S_REPORT without scoring.
REQ-030 If DONE and timeout occur on the same edge, DONE SHALL win.
REQ-031 S_SCORE: one point per cycle for NPTS cycles, covered iff dx1^2+dy1^2<=RSQ OR dx2^2+dy2^2<=RSQ.
REQ-032 dx/dy SHALL be 4-bit absolute differences and each squared sum SHALL be 9-bit unsigned; equality to RSQ counts as covered.
REQ-033 The coverage counter SHALL be 6 bits, count 0..NPTS, and never wrap.
REQ-034 After the last point is scored, R_COV<=count and the state SHALL become S_REPORT.
REQ-035 S_REPORT: R_VALID=1 for exactly one cycle, then ldcnt<=0 and the state SHALL become S_LOAD.
REQ-036 R_* SHALL hold their values until the next capture or timeout.
REQ-037 The buffer SHALL be reloaded fully for each run; no partial-image start.
REQ-038 Latency, last load to LRST low: 0 edges (the same edge). DONE capture to R_VALID: NPTS+1 cycles.

Reset
REQ-039 RST=1 SHALL force S_LOAD with ldcnt=idx=0, LRST=1, LX=LY=0, R_C*=0, R_COV=0, R_ERR=0, R_VALID=0, BUSY=0 and LD_READY=1, immediately and asynchronously.
REQ-040 RST during any state SHALL abort the run; LRST SHALL go high at once, holding the engine in reset.
REQ-041 Buffer contents SHALL be don't-care after reset.

Verification
REQ-042 Load 40 x (5,5) -> LRST falls on the 40th load edge; LX/LY=5 for 40 cycles; engine model returns (5,5),(5,5) -> R_COV=40, R_ERR=0, single R_VALID.
REQ-043 Load 20 x (0,0) + 20 x (15,15); model returns C1=(0,0), C2=(15,15) -> R_COV=40; same run with C1=C2=(8,8) -> R_COV=0.
REQ-044 Points (4,0) and (3,3), center (0,0) -> (4,0) covered (16), (3,3) not covered (18); R_COV=1 plus the remaining points per model.
REQ-045 TIMEOUT=100, DONE held low -> R_VALID with R_ERR=1, R_COV=0, exactly 100 cycles after S_WAIT entry; LRST=1.
REQ-046 RST pulsed at send index 17 -> LRST=1 and LD_READY=1 immediately; the next 40 loads run a clean image.
REQ-047 LD_VALID pulsed during S_WAIT/S_SCORE -> buffer unchanged and results identical to an unperturbed run.

Source files
------------

// File: rtl/laser_host_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// laser_host_if : point/center bus between the host and the LASER engine.
// Rev 1.0
// ---------------------------------------------------------------------------
interface laser_host_if;
  logic       LRST;
  logic [3:0] LX;
  logic [3:0] LY;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic       DONE;

  modport master (
    output LRST, LX, LY,
    input  C1X, C1Y, C2X, C2Y, DONE
  );

  modport slave (
    input  LRST, LX, LY,
    output C1X, C1Y, C2X, C2Y, DONE
  );
endinterface
`default_nettype wire

// File: rtl/laser_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// laser_host : buffers an image, streams it to the LASER engine, then scores
//              coverage of the returned two centers.  Rev 1.0
// ---------------------------------------------------------------------------
module laser_host #(
  parameter int NPTS    = 40,
  parameter int RSQ     = 16,
  parameter int TIMEOUT = 200000
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_VALID,
  input  logic [3:0]    LD_X,
  input  logic [3:0]    LD_Y,
  output logic          LD_READY,
  laser_host_if.master  eng,
  output logic [3:0]    R_C1X,
  output logic [3:0]    R_C1Y,
  output logic [3:0]    R_C2X,
  output logic [3:0]    R_C2Y,
  output logic [5:0]    R_COV,
  output logic          R_ERR,
  output logic          R_VALID,
  output logic          BUSY
);

  localparam int CW = $clog2(NPTS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NPTS - 1);
  localparam logic [CW-1:0] END_IDX  = CW'(NPTS);
  localparam logic [WW-1:0] TMO_LAST = WW'(TIMEOUT - 1);
  localparam logic [8:0]    RSQ9     = 9'(RSQ);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_SEND   = 3'd1,
    S_WAIT   = 3'd2,
    S_SCORE  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [7:0]    pts [NPTS];
  logic [CW-1:0] ldcnt;
  logic [CW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic [5:0]    cov;
  logic [7:0]    cur;
  logic          hit;

  function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                       input logic [3:0] bx, input logic [3:0] by);
    logic [8:0] dx;
    logic [8:0] dy;
    dx = {5'd0, (ax >= bx) ? (ax - bx) : (bx - ax)};
    dy = {5'd0, (ay >= by) ? (ay - by) : (by - ay)};
    return dx * dx + dy * dy;
  endfunction

  // Scoring uses the centers latched on DONE; the engine outputs are stale by then.
  assign cur = pts[idx];
  assign hit = (dist2(cur[7:4], cur[3:0], R_C1X, R_C1Y) <= RSQ9) ||
               (dist2(cur[7:4], cur[3:0], R_C2X, R_C2Y) <= RSQ9);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    LD_READY = 1'b0;
    BUSY     = 1'b1;
    R_VALID  = 1'b0;
    case (state)
      S_LOAD: begin
        LD_READY = 1'b1;
        BUSY     = 1'b0;
        if (LD_VALID && ldcnt == LAST_IDX) state_nx = S_SEND;
      end
      S_SEND: begin
        if (idx == END_IDX) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (eng.DONE)              state_nx = S_SCORE;
        else if (wcnt == TMO_LAST) state_nx = S_REPORT;
      end
      S_SCORE: begin
        if (idx == END_IDX) state_nx = S_REPORT;
      end
      S_REPORT: begin
        R_VALID  = 1'b1;
        state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST && state == S_LOAD && LD_VALID) pts[ldcnt] <= {LD_X, LD_Y};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ldcnt    <= '0;
      idx      <= '0;
      wcnt     <= '0;
      cov      <= '0;
      eng.LRST <= 1'b1;
      eng.LX   <= 4'd0;
      eng.LY   <= 4'd0;
      R_C1X    <= 4'd0;
      R_C1Y    <= 4'd0;
      R_C2X    <= 4'd0;
      R_C2Y    <= 4'd0;
      R_COV    <= 6'd0;
      R_ERR    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (LD_VALID) begin
            ldcnt <= ldcnt + 1'b1;
            if (ldcnt == LAST_IDX) begin
              // Point 0 goes out on the same edge; bypass covers NPTS == 1.
              eng.LRST           <= 1'b0;
              {eng.LX, eng.LY}   <= (ldcnt == '0) ? {LD_X, LD_Y} : pts[0];
              idx                <= CW'(1);
            end
          end
        end
        S_SEND: begin
          if (idx == END_IDX) begin
            eng.LX <= 4'd0;
            eng.LY <= 4'd0;
            wcnt   <= '0;
          end else begin
            {eng.LX, eng.LY} <= cur;
            idx              <= idx + 1'b1;
          end
        end
        S_WAIT: begin
          if (eng.DONE) begin
            R_C1X    <= eng.C1X;
            R_C1Y    <= eng.C1Y;
            R_C2X    <= eng.C2X;
            R_C2Y    <= eng.C2Y;
            R_ERR    <= 1'b0;
            eng.LRST <= 1'b1;
            idx      <= '0;
            cov      <= '0;
          end else if (wcnt == TMO_LAST) begin
            R_C1X    <= 4'd0;
            R_C1Y    <= 4'd0;
            R_C2X    <= 4'd0;
            R_C2Y    <= 4'd0;
            R_COV    <= 6'd0;
            R_ERR    <= 1'b1;
            eng.LRST <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_SCORE: begin
          if (idx == END_IDX) begin
            R_COV <= cov;
          end else begin
            if (hit && cov != 6'h3F) cov <= cov + 1'b1;
            idx <= idx + 1'b1;
          end
        end
        S_REPORT: begin
          ldcnt <= '0;
          idx   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_host.sv
`default_nettype none
// tb_laser_host : directed bench with a scripted engine model and
//                 hand-computed coverage results.
module tb_laser_host;
  localparam int NPTS = 40;
  localparam int TMO  = 100;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LD_VALID;
  logic [3:0] LD_X;
  logic [3:0] LD_Y;
  logic       LD_READY;
  logic [3:0] R_C1X;
  logic [3:0] R_C1Y;
  logic [3:0] R_C2X;
  logic [3:0] R_C2Y;
  logic [5:0] R_COV;
  logic       R_ERR;
  logic       R_VALID;
  logic       BUSY;

  laser_host_if eng ();

  laser_host #(.NPTS(NPTS), .RSQ(16), .TIMEOUT(TMO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LD_VALID (LD_VALID),
    .LD_X     (LD_X),
    .LD_Y     (LD_Y),
    .LD_READY (LD_READY),
    .eng      (eng),
    .R_C1X    (R_C1X),
    .R_C1Y    (R_C1Y),
    .R_C2X    (R_C2X),
    .R_C2Y    (R_C2Y),
    .R_COV    (R_COV),
    .R_ERR    (R_ERR),
    .R_VALID  (R_VALID),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] img [NPTS];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic load_image(input string name);
    int rdy_err;
    rdy_err = 0;
    for (int i = 0; i < NPTS; i++) begin
      @(negedge CLK);
      if (LD_READY !== 1'b1) rdy_err++;
      if (i == NPTS - 1) check_val({name, "_lrst_before_last"}, eng.LRST, 1);
      LD_VALID = 1'b1;
      {LD_X, LD_Y} = img[i];
    end
    @(negedge CLK);
    LD_VALID = 1'b0;
    check_val({name, "_ld_ready_during_load"}, rdy_err, 0);
    check_val({name, "_lrst_fall"}, eng.LRST, 0);
    check_val({name, "_busy_after_load"}, {LD_READY, BUSY}, 2'b01);
  endtask

  // mode: 0 normal, 1 timeout, 2 normal with stray LD_VALID, 3 reset at send index 17
  task automatic run(input string name, input int mode,
                     input logic [3:0] c1x, input logic [3:0] c1y,
                     input logic [3:0] c2x, input logic [3:0] c2y,
                     input int exp_cov);
    int errs;
    int cyc;
    load_image(name);
    errs = 0;
    for (int k = 0; k < NPTS; k++) begin
      if (k > 0) @(negedge CLK);
      if ({eng.LX, eng.LY} !== img[k] || eng.LRST !== 1'b0) errs++;
      if (mode == 3 && k == 17) begin
        #2 RST = 1'b1;
        #1;
        check_val({name, "_abort_lrst"}, eng.LRST, 1);
        check_val({name, "_abort_ready_busy"}, {LD_READY, BUSY, R_VALID}, 3'b100);
        check_val({name, "_abort_results"}, {R_C1X, R_C1Y, R_C2X, R_C2Y, R_COV, R_ERR}, 0);
        check_val({name, "_abort_lxly"}, {eng.LX, eng.LY}, 0);
        check_val({name, "_abort_send_prefix"}, errs, 0);
        @(negedge CLK);
        RST = 1'b0;
        return;
      end
    end
    check_val({name, "_send_seq"}, errs, 0);
    @(negedge CLK);
    check_val({name, "_lxly_idle"}, {eng.LX, eng.LY, eng.LRST}, 0);
    if (mode == 1) begin
      cyc = 0;
      while (!R_VALID && cyc < 300) begin
        @(negedge CLK);
        cyc++;
      end
      check_val({name, "_timeout_cycles"}, cyc, TMO);
      check_val({name, "_timeout_err"}, R_ERR, 1);
      check_val({name, "_timeout_results"}, {R_C1X, R_C1Y, R_C2X, R_C2Y, R_COV}, 0);
      check_val({name, "_timeout_lrst"}, eng.LRST, 1);
    end else begin
      for (int w = 0; w < 3; w++) begin
        if (mode == 2) begin
          LD_VALID = 1'b1;
          {LD_X, LD_Y} = 8'h88;
        end
        @(negedge CLK);
      end
      LD_VALID = 1'b0;
      {eng.C1X, eng.C1Y, eng.C2X, eng.C2Y} = {c1x, c1y, c2x, c2y};
      eng.DONE = 1'b1;
      @(negedge CLK);
      eng.DONE = 1'b0;
      {eng.C1X, eng.C1Y, eng.C2X, eng.C2Y} = 16'h8888;
      check_val({name, "_lrst_after_done"}, eng.LRST, 1);
      cyc = 0;
      while (!R_VALID && cyc < 300) begin
        LD_VALID = (mode == 2 && cyc >= 2 && cyc <= 5);
        @(negedge CLK);
        cyc++;
      end
      LD_VALID = 1'b0;
      check_val({name, "_done_to_valid"}, cyc, NPTS + 1);
      check_val({name, "_cov"}, R_COV, exp_cov);
      check_val({name, "_err"}, R_ERR, 0);
      check_val({name, "_centers"}, {R_C1X, R_C1Y, R_C2X, R_C2Y}, {c1x, c1y, c2x, c2y});
    end
    @(negedge CLK);
    check_val({name, "_valid_one_cycle"}, {R_VALID, LD_READY, BUSY}, 3'b010);
  endtask

  initial begin
    RST      = 1'b1;
    LD_VALID = 1'b0;
    LD_X     = 4'd0;
    LD_Y     = 4'd0;
    eng.DONE = 1'b0;
    {eng.C1X, eng.C1Y, eng.C2X, eng.C2Y} = 16'h0;
    #1;
    check_val("reset_lrst", eng.LRST, 1);
    check_val("reset_lxly", {eng.LX, eng.LY}, 0);
    check_val("reset_flags", {LD_READY, BUSY, R_VALID, R_ERR}, 4'b1000);
    check_val("reset_results", {R_C1X, R_C1Y, R_C2X, R_C2Y, R_COV}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NPTS; i++) img[i] = 8'h55;
    run("all55", 0, 4'd5, 4'd5, 4'd5, 4'd5, 40);

    for (int i = 0; i < NPTS; i++) img[i] = (i < 20) ? 8'h00 : 8'hFF;
    run("timeout", 1, 4'd0, 4'd0, 4'd15, 4'd15, 0);
    run("corners_poke", 2, 4'd0, 4'd0, 4'd15, 4'd15, 40);
    run("abort17", 3, 4'd0, 4'd0, 4'd15, 4'd15, 0);

    // (4,0):16 yes, (3,3):18 no, (0,4):16 yes, (15,11):16 yes, (12,13):13 yes, (11,12):25 no
    for (int i = 0; i < NPTS; i++) img[i] = 8'h88;
    img[0] = 8'h40; img[1] = 8'h33; img[2] = 8'h04;
    img[3] = 8'hFB; img[4] = 8'hCD; img[5] = 8'hBC;
    run("boundary", 0, 4'd0, 4'd0, 4'd15, 4'd15, 4);

    for (int i = 0; i < NPTS; i++) img[i] = (i < 20) ? 8'h00 : 8'hFF;
    run("center88", 0, 4'd8, 4'd8, 4'd8, 4'd8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
